i2c_slave: RTL
==============

I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h58, the 7-bit address the block responds to.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, the synchronizer depth on scl/sda inputs (minimum 2).
REQ-003 clk  input  1  system clock; at least 8x the SCL frequency.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 scl  input  1  I2C clock from the bus; asynchronous.
REQ-006 sda_in  input  1  I2C data as read from the bus; asynchronous.
REQ-007 sda_oe  output  1  1 = pull SDA low (open-drain), 0 = release.
REQ-008 rx_data  output  8  last byte written by the master, MSB first.
REQ-009 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-010 tx_data  input  8  byte to return on a master read.
REQ-011 tx_load  output  1  one-cycle pulse on the clk cycle in which tx_data is captured.
REQ-012 start_det, stop_det  output  1 each  one-cycle pulses on bus START (including repeated START) and on STOP.
REQ-013 busy  output  1  high from an address match until the transaction ends.

Function
REQ-014 scl and sda_in SHALL pass through SYNC_STAGES flops, then one history flop; all edge detection uses the synchronized signals.
REQ-015 START SHALL be a falling synchronized SDA while synchronized SCL is high; STOP SHALL be a rising synchronized SDA while synchronized SCL is high.
REQ-016 States SHALL be IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT.
REQ-017 START from any state -> ADDR with the bit counter cleared; STOP from any state -> IDLE with sda_oe=0; START/STOP takes priority over an SCL edge in the same cycle.
REQ-018 Data bits SHALL be sampled on the synchronized SCL rising edge; sda_oe SHALL change only on the cycle after a synchronized SCL falling edge.
REQ-019 ADDR: shift in 8 bits (7 address bits, then R/W); on the 8th rising edge compare with SLAVE_ADDR.
REQ-020 On a match, the following falling edge SHALL assert sda_oe for ADDR_ACK and set busy; on a mismatch, go to WAIT and keep sda_oe=0.
REQ-021 With R/W=0, after the ACK-clock falling edge SHALL release sda_oe and enter RX.
REQ-022 With R/W=1, after the ACK-clock falling edge SHALL pulse tx_load, capture tx_data, drive bit 7 (sda_oe = ~bit), and enter TX.
REQ-023 RX: after 8 bits, rx_data SHALL update and rx_valid SHALL pulse on the cycle after the 8th rising edge; then ACK (sda_oe=1) for one SCL period in RX_ACK, then return to RX.
REQ-024 TX: drive each remaining bit after every falling edge, MSB first; after the 8th bit, release sda_oe and sample the master ACK on the 9th rising edge in TX_ACK.
REQ-025 Master ACK (SDA low) SHALL capture the next byte (tx_load pulse) and continue in TX; NACK SHALL go to WAIT with sda_oe=0.
REQ-026 WAIT SHALL ignore SCL edges and leave only on START or STOP.
REQ-027 busy SHALL clear on STOP or on entry to WAIT; a repeated START re-evaluates the address.
REQ-028 The block SHALL never stretch SCL and never drive SDA high.

Reset
REQ-029 While reset is high: state=IDLE, sda_oe=0, rx_data=8'h00, rx_valid=0, tx_load=0, start_det=0, stop_det=0, busy=0, synchronizers loaded with 1.
REQ-030 Reset mid-transaction SHALL release SDA within one clk cycle; after reset the block responds only after a new START.

Verification
REQ-031 Write 0xB0 (addr 0x58, W) then 0x3A, STOP -> ACK on both bytes, rx_valid pulses once with rx_data=0x3A, stop_det pulses, busy clears.
REQ-032 Write to addr 0x21 -> no ACK (sda_oe stays 0), no rx_valid, busy stays 0, state WAIT until STOP.
REQ-033 Read 0xB1 with tx_data=0xA5 then 0x5A, master ACK then NACK -> bus shows 0xA5 then 0x5A, two tx_load pulses, sda_oe=0 after the NACK.
REQ-034 Write 0xB0, 0x10, repeated START, 0xB1, read one byte -> start_det pulses twice, a single rx_valid with 0x10, then the read is served.
REQ-035 Assert reset while driving a TX bit 0 -> sda_oe=0 the next cycle; the following bytes are ignored until a new START.
REQ-036 STOP in the middle of an RX byte (bit 4) -> IDLE, no rx_valid, stop_det pulses.

Source files
------------

// File: rtl/i2c_slave.sv
// I2C target (slave) with a 7-bit address: receives written bytes, serves read bytes
// from tx_data, never stretches SCL and only ever pulls SDA low.
`timescale 1ns/1ps
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h58,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_load,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy
);

    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX,
        ST_RX_ACK,
        ST_TX,
        ST_TX_ACK,
        ST_WAIT
    } state_t;

    logic [STAGES-1:0] scl_sync_r;
    logic [STAGES-1:0] sda_sync_r;
    logic              scl_hist_r;
    logic              sda_hist_r;

    logic              scl_now_s;
    logic              sda_now_s;
    logic              scl_rise_s;
    logic              scl_fall_s;
    logic              start_s;
    logic              stop_s;

    state_t            state_r;
    logic [3:0]        bit_cnt_r;
    logic [6:0]        shift_r;
    logic [7:0]        tx_shift_r;
    logic              match_r;
    logic              rw_r;

    // Bring the asynchronous bus lines into the clk domain and keep one cycle of history.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_sync_r <= '1;
            sda_sync_r <= '1;
            scl_hist_r <= 1'b1;
            sda_hist_r <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[STAGES-2:0], scl};
            sda_sync_r <= {sda_sync_r[STAGES-2:0], sda_in};
            scl_hist_r <= scl_sync_r[STAGES-1];
            sda_hist_r <= sda_sync_r[STAGES-1];
        end
    end

    assign scl_now_s  = scl_sync_r[STAGES-1];
    assign sda_now_s  = sda_sync_r[STAGES-1];
    assign scl_rise_s = scl_now_s & ~scl_hist_r;
    assign scl_fall_s = ~scl_now_s & scl_hist_r;
    assign start_s    = scl_now_s & scl_hist_r & sda_hist_r & ~sda_now_s;
    assign stop_s     = scl_now_s & scl_hist_r & ~sda_hist_r & sda_now_s;

    // Protocol state machine; bus conditions override any SCL edge seen in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 7'd0;
            tx_shift_r <= 8'd0;
            match_r    <= 1'b0;
            rw_r       <= 1'b0;
            sda_oe     <= 1'b0;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            tx_load    <= 1'b0;
            start_det  <= 1'b0;
            stop_det   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            tx_load   <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            if (start_s) begin
                state_r   <= ST_ADDR;
                bit_cnt_r <= 4'd0;
                sda_oe    <= 1'b0;
                start_det <= 1'b1;
            end else if (stop_s) begin
                state_r   <= ST_IDLE;
                bit_cnt_r <= 4'd0;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
                stop_det  <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        sda_oe <= 1'b0;
                    end
                    ST_ADDR: begin
                        if (scl_rise_s) begin
                            shift_r   <= {shift_r[5:0], sda_now_s};
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            if (bit_cnt_r == 4'd7) begin
                                match_r <= (shift_r == SLAVE_ADDR);
                                rw_r    <= sda_now_s;
                            end else begin
                                match_r <= match_r;
                            end
                        end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
                            if (match_r) begin
                                sda_oe  <= 1'b1;
                                busy    <= 1'b1;
                                state_r <= ST_ADDR_ACK;
                            end else begin
                                sda_oe  <= 1'b0;
                                busy    <= 1'b0;
                                state_r <= ST_WAIT;
                            end
                        end else begin
                            state_r <= ST_ADDR;
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall_s) begin
                            if (rw_r) begin
                                // First read byte: capture and put its MSB on the bus right away.
                                tx_load    <= 1'b1;
                                tx_shift_r <= {tx_data[6:0], 1'b0};
                                sda_oe     <= ~tx_data[7];
                                bit_cnt_r  <= 4'd1;
                                state_r    <= ST_TX;
                            end else begin
                                sda_oe    <= 1'b0;
                                bit_cnt_r <= 4'd0;
                                state_r   <= ST_RX;
                            end
                        end else begin
                            state_r <= ST_ADDR_ACK;
                        end
                    end
                    ST_RX: begin
                        if (scl_rise_s) begin
                            shift_r   <= {shift_r[5:0], sda_now_s};
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            if (bit_cnt_r == 4'd7) begin
                                rx_data  <= {shift_r, sda_now_s};
                                rx_valid <= 1'b1;
                            end else begin
                                rx_valid <= 1'b0;
                            end
                        end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
                            sda_oe  <= 1'b1;
                            state_r <= ST_RX_ACK;
                        end else begin
                            state_r <= ST_RX;
                        end
                    end
                    ST_RX_ACK: begin
                        if (scl_fall_s) begin
                            sda_oe    <= 1'b0;
                            bit_cnt_r <= 4'd0;
                            state_r   <= ST_RX;
                        end else begin
                            state_r <= ST_RX_ACK;
                        end
                    end
                    ST_TX: begin
                        if (scl_fall_s) begin
                            if (bit_cnt_r == 4'd8) begin
                                sda_oe  <= 1'b0;
                                state_r <= ST_TX_ACK;
                            end else begin
                                sda_oe     <= ~tx_shift_r[7];
                                tx_shift_r <= {tx_shift_r[6:0], 1'b0};
                                bit_cnt_r  <= bit_cnt_r + 4'd1;
                            end
                        end else begin
                            state_r <= ST_TX;
                        end
                    end
                    ST_TX_ACK: begin
                        if (scl_rise_s) begin
                            if (!sda_now_s) begin
                                // Next byte's MSB goes out on the following falling edge.
                                tx_load    <= 1'b1;
                                tx_shift_r <= tx_data;
                                bit_cnt_r  <= 4'd0;
                                state_r    <= ST_TX;
                            end else begin
                                busy    <= 1'b0;
                                state_r <= ST_WAIT;
                            end
                        end else begin
                            state_r <= ST_TX_ACK;
                        end
                    end
                    ST_WAIT: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        sda_oe  <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
